path_move_checker: RTL
======================

// Module: path_move_checker
// PURPOSE
//  Sequential move validator in the game-logic path. For a requested src->dst move it walks
//  every intermediate square through the board read port, confirms the path is clear, then
//  reads dst and applies the own-colour rule (no capture of own piece; empty dst always OK).
//  Parametrised successor of the combinational colour check: any board size and piece width.
// PARAMETERS
//  BOARD_DIM  8   squares per side; legal coords 0..BOARD_DIM-1
//  COORD_W    3   coordinate width; must satisfy 2**COORD_W >= BOARD_DIM
//  PIECE_W    4   piece code width; MSB = colour, [PIECE_W-2:0] = type, type 0 = empty
// PORTS
//  clk          in   1        system clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        request pulse; sampled only in IDLE
//  src_x,src_y  in   COORD_W  source square
//  dst_x,dst_y  in   COORD_W  destination square
//  cur_piece    in   PIECE_W  piece being moved; latched with start
//  rd_en        out  1        board read strobe
//  rd_x,rd_y    out  COORD_W  board read address
//  rd_data      in   PIECE_W  board contents; valid exactly 1 cycle after rd_en
//  busy         out  1        high from cycle after start accept until done
//  done         out  1        one-cycle pulse; result outputs valid from this cycle
//  allow        out  1        path_clear & allow_colour & geometry valid
//  path_clear   out  1        no occupied intermediate square
//  allow_colour out  1        dst empty or opposite colour to cur_piece
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; rd_x/rd_y 0. Reset mid-walk aborts, no done pulse.
//  FSM: IDLE -start-> SETUP -> RD -> CHK -> (RD | DONE) ; DONE -> IDLE.
//   SETUP: latch inputs; dx=dst_x-src_x, dy=dst_y-src_y (signed COORD_W+1); step sx,sy in
//    {-1,0,+1}; n = max(|dx|,|dy|). Geometry valid iff coords < BOARD_DIM, src!=dst, and
//    (dx==0 | dy==0 | |dx|==|dy| | knight shape {1,2}/{2,1}). Invalid -> DONE, all results 0, no reads.
//   Knight shape: no intermediate reads; only dst read.
//   RD: rd_en=1 for one cycle, address = src + k*(sx,sy), k=1..n-1, then dst.
//   CHK: sample rd_data. Intermediate type!=0 -> path_clear=0, go DONE (early exit, dst not
//    read, allow_colour=0). dst: allow_colour = (cur[MSB]^rd[MSB]) | (rd type==0).
//  Timing: start sampled in cycle T; k reads (intermediates+dst) -> done in cycle T+2+2k.
//  start while busy or in DONE is ignored (not queued). Results hold until next accept.
//  busy=0 and done=1 in DONE cycle; accept of a new start possible the cycle after.
// CONFIGURATION
//  KING_CAPTURE_BLOCK_EN: if defined, dst type == KING forces allow_colour=0 (king never
//   captured; mate handled elsewhere). Undefined: kings obey the plain colour rule.
// STRUCTURE
//  Package chess_pkg: PT_EMPTY=0, PT_PAWN=1, PT_KNIGHT=2, PT_BISHOP=3, PT_ROOK=4,
//   PT_QUEEN=5, PT_KING=6; colour encoding; FSM state enum; coord/piece typedefs.
//  Sub-module colour_allow (combinational: cur, tgt -> allow) instanced once for dst check.
// TESTING
//  Rook (0,0)->(0,7), empty column, dst empty -> 7 reads, done at T+16, allow=1.
//  Bishop (2,0)->(5,3), (4,2) occupied -> reads (3,1),(4,2) only, path_clear=0, allow=0.
//  Knight (1,0)->(2,2), cur=4'b0010, dst=4'b1100 -> 1 read, allow_colour=1, allow=1, T+4.
//  Queen (3,3)->(3,4), cur=4'b1101, dst=4'b1001 (own) -> allow_colour=0, allow=0.
//  src=dst or (0,0)->(1,3) -> no rd_en, done at T+2, allow=0; start during busy ignored.
//  rst asserted mid-walk -> outputs 0 at once, no done; KING_CAPTURE_BLOCK_EN dst=king -> allow=0.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared piece codes, colour encoding, FSM states and coordinate/piece types
// for the move-validation path.
package chess_pkg;

   localparam int PT_EMPTY  = 0;
   localparam int PT_PAWN   = 1;
   localparam int PT_KNIGHT = 2;
   localparam int PT_BISHOP = 3;
   localparam int PT_ROOK   = 4;
   localparam int PT_QUEEN  = 5;
   localparam int PT_KING   = 6;

   // Colour lives in the piece MSB.
   localparam logic COLOUR_WHITE = 1'b0;
   localparam logic COLOUR_BLACK = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_RD,
      S_CHK,
      S_DONE
   } state_t;

   typedef logic [2:0] coord_t;
   typedef logic [3:0] piece_t;

endpackage

// File: rtl/path_move_checker_colour_allow.sv
// colour_allow: destination capture rule (empty or opposite colour).
// Build option KING_CAPTURE_BLOCK_EN additionally refuses any king destination.
module colour_allow #(
   parameter int PIECE_W = 4
) (
   input  logic [PIECE_W-1:0] i_cur,
   input  logic [PIECE_W-1:0] i_tgt,
   output logic               o_allow
);
   import chess_pkg::*;

   localparam int TW = PIECE_W - 1;

   logic w_tgt_empty;
   logic w_opp_colour;
   logic w_unused_cur_type;

   assign w_tgt_empty  = (i_tgt[TW-1:0] == TW'(PT_EMPTY));
   assign w_opp_colour = i_cur[PIECE_W-1] ^ i_tgt[PIECE_W-1];

`ifdef KING_CAPTURE_BLOCK_EN
   assign o_allow = (w_opp_colour | w_tgt_empty) & (i_tgt[TW-1:0] != TW'(PT_KING));
`else
   assign o_allow = w_opp_colour | w_tgt_empty;
`endif

   // Only the colour of the moving piece matters here.
   assign w_unused_cur_type = &{1'b0, i_cur[TW-1:0]};

endmodule

// File: rtl/path_move_checker.sv
// Sequential move validator: walks the src->dst path through the board read port
// and applies the capture rule to dst (KING_CAPTURE_BLOCK_EN handled in colour_allow).
//
// state   | meaning
// IDLE    | waiting for start
// SETUP   | geometry check, first read address
// RD      | rd_en high for one cycle
// CHK     | sample rd_data, next read or finish
// DONE    | done pulse, results valid
module path_move_checker #(
   parameter int BOARD_DIM = 8,
   parameter int COORD_W   = 3,
   parameter int PIECE_W   = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [COORD_W-1:0] i_src_x,
   input  logic [COORD_W-1:0] i_src_y,
   input  logic [COORD_W-1:0] i_dst_x,
   input  logic [COORD_W-1:0] i_dst_y,
   input  logic [PIECE_W-1:0] i_cur_piece,
   output logic               o_rd_en,
   output logic [COORD_W-1:0] o_rd_x,
   output logic [COORD_W-1:0] o_rd_y,
   input  logic [PIECE_W-1:0] i_rd_data,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_allow,
   output logic               o_path_clear,
   output logic               o_allow_colour
);
   import chess_pkg::*;

   localparam int DW = COORD_W + 1;
   localparam logic [DW-1:0] LP_DIM = DW'(BOARD_DIM);

   state_t             r_state;
   logic [COORD_W-1:0] r_src_x, r_src_y, r_dst_x, r_dst_y;
   logic [COORD_W-1:0] r_step_x, r_step_y;
   logic [PIECE_W-1:0] r_cur;
   logic [DW-1:0]      r_cnt;
   logic               r_is_dst;

   logic signed [DW-1:0] w_dx, w_dy;
   logic [DW-1:0]        w_adx, w_ady, w_n;
   logic [COORD_W-1:0]   w_sx, w_sy;
   logic                 w_knight, w_line, w_same, w_in_range, w_geom_ok;
   logic                 w_rd_empty, w_allow_col;

   assign w_dx  = $signed({1'b0, r_dst_x}) - $signed({1'b0, r_src_x});
   assign w_dy  = $signed({1'b0, r_dst_y}) - $signed({1'b0, r_src_y});
   assign w_adx = w_dx[DW-1] ? (~w_dx + DW'(1)) : w_dx;
   assign w_ady = w_dy[DW-1] ? (~w_dy + DW'(1)) : w_dy;
   assign w_n   = (w_adx > w_ady) ? w_adx : w_ady;

   // Step is kept as a COORD_W-bit two's complement value so address update wraps naturally.
   assign w_sx = (w_dx == '0) ? '0 : (w_dx[DW-1] ? '1 : COORD_W'(1));
   assign w_sy = (w_dy == '0) ? '0 : (w_dy[DW-1] ? '1 : COORD_W'(1));

   assign w_knight   = ((w_adx == DW'(1)) && (w_ady == DW'(2))) ||
                       ((w_adx == DW'(2)) && (w_ady == DW'(1)));
   assign w_line     = (w_adx == '0) || (w_ady == '0) || (w_adx == w_ady);
   assign w_same     = (r_src_x == r_dst_x) && (r_src_y == r_dst_y);
   assign w_in_range = ({1'b0, r_src_x} < LP_DIM) && ({1'b0, r_src_y} < LP_DIM) &&
                       ({1'b0, r_dst_x} < LP_DIM) && ({1'b0, r_dst_y} < LP_DIM);
   assign w_geom_ok  = w_in_range && !w_same && (w_line || w_knight);

   assign w_rd_empty = (i_rd_data[PIECE_W-2:0] == '0);

   colour_allow #(.PIECE_W(PIECE_W)) u_colour_allow (
      .i_cur   (r_cur),
      .i_tgt   (i_rd_data),
      .o_allow (w_allow_col)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_src_x        <= '0;
         r_src_y        <= '0;
         r_dst_x        <= '0;
         r_dst_y        <= '0;
         r_step_x       <= '0;
         r_step_y       <= '0;
         r_cur          <= '0;
         r_cnt          <= '0;
         r_is_dst       <= 1'b0;
         o_rd_en        <= 1'b0;
         o_rd_x         <= '0;
         o_rd_y         <= '0;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         o_allow        <= 1'b0;
         o_path_clear   <= 1'b0;
         o_allow_colour <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  r_src_x        <= i_src_x;
                  r_src_y        <= i_src_y;
                  r_dst_x        <= i_dst_x;
                  r_dst_y        <= i_dst_y;
                  r_cur          <= i_cur_piece;
                  o_busy         <= 1'b1;
                  o_allow        <= 1'b0;
                  o_path_clear   <= 1'b0;
                  o_allow_colour <= 1'b0;
                  r_state        <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (!w_geom_ok) begin
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_step_x <= w_sx;
                  r_step_y <= w_sy;
                  o_rd_en  <= 1'b1;
                  r_state  <= S_RD;
                  if (w_knight || (w_n == DW'(1))) begin
                     o_rd_x   <= r_dst_x;
                     o_rd_y   <= r_dst_y;
                     r_is_dst <= 1'b1;
                  end else begin
                     o_rd_x   <= r_src_x + w_sx;
                     o_rd_y   <= r_src_y + w_sy;
                     r_cnt    <= w_n - DW'(2);
                     r_is_dst <= 1'b0;
                  end
               end
            end
            S_RD: begin
               o_rd_en <= 1'b0;
               r_state <= S_CHK;
            end
            S_CHK: begin
               if (r_is_dst) begin
                  o_path_clear   <= 1'b1;
                  o_allow_colour <= w_allow_col;
                  o_allow        <= w_allow_col;
                  o_busy         <= 1'b0;
                  o_done         <= 1'b1;
                  r_state        <= S_DONE;
               end else if (!w_rd_empty) begin
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  o_rd_en <= 1'b1;
                  r_state <= S_RD;
                  if (r_cnt == '0) begin
                     o_rd_x   <= r_dst_x;
                     o_rd_y   <= r_dst_y;
                     r_is_dst <= 1'b1;
                  end else begin
                     o_rd_x <= o_rd_x + r_step_x;
                     o_rd_y <= o_rd_y + r_step_y;
                     r_cnt  <= r_cnt - DW'(1);
                  end
               end
            end
            S_DONE: begin
               o_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
